first_nios2_system_sysid_checker: RTL
=====================================

Name: first_nios2_system_sysid_checker

Overview:
Avalon-MM read master that sits opposite the system ID slave. On start, it reads the ID word (word offset 0) and the timestamp word (word offset 1). It compares both against build-time constants and reports pass/fail/timeout to the boot/status logic. This gives hardware a self-check that the loaded FPGA image matches the expected system before software is released.

Parameters:
EXPECTED_ID, 32'd7, value required at word offset 0
EXPECTED_TS, 32'd1382619795, value required at word offset 1
TIMEOUT_CYCLES, 256, maximum cycles a single read may be stalled by waitrequest; allowed range 2..65535
AUTO_START, 1, 1 = start one check automatically in the first cycle after reset deasserts

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  synchronous active-high reset
start  in  1  single-cycle pulse that requests a check; ignored while busy
m_address  out  1  Avalon word address: 0 = ID, 1 = timestamp
m_read  out  1  Avalon read strobe
m_waitrequest  in  1  slave stall
m_readdata  in  32  read data, valid in a cycle where m_read=1 and m_waitrequest=0
busy  out  1  check in progress
done  out  1  check finished; held until the next accepted start or reset
id_ok  out  1  captured ID == EXPECTED_ID (valid when done=1)
ts_ok  out  1  captured timestamp == EXPECTED_TS (valid when done=1)
timeout  out  1  a read exceeded TIMEOUT_CYCLES (valid when done=1)
captured_id  out  32  last ID word read
captured_ts  out  32  last timestamp word read

Behaviour:
- Reset (synchronous, dominant over every other input): FSM to IDLE. All outputs 0: m_read, m_address, busy, done, id_ok, ts_ok, timeout, captured_id, captured_ts. Wait counter cleared.
- Reset asserted mid-read: m_read drops in the cycle after the reset edge. No partial result is retained.
- FSM states: IDLE, RD_ID, RD_TS, FIN.
- IDLE -> RD_ID on start=1, or on the first post-reset cycle if AUTO_START=1. On that transition: clear done, id_ok, ts_ok and timeout; set busy=1.
- RD_ID:
  - Drive m_read=1, m_address=0.
  - m_read and m_address stay stable while m_waitrequest=1 (Avalon rule).
  - In the cycle m_waitrequest=0: capture m_readdata into captured_id, then go to RD_TS. m_read stays high with m_address=1 the next cycle (back-to-back reads allowed).
- RD_TS: same as RD_ID but m_address=1; the capture goes to captured_ts, then go to FIN.
- Zero-wait slave: a full check takes 2 read cycles. done rises in cycle 3 after the start edge.
- FIN (one cycle):
  - m_read=0.
  - id_ok = (captured_id == EXPECTED_ID); ts_ok = (captured_ts == EXPECTED_TS); both are full 32-bit compares.
  - done=1, busy=0, then go to IDLE.
  - done, id_ok, ts_ok and timeout hold in IDLE.
- Timeout:
  - The wait counter resets at each read entry and increments each cycle m_waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES: drop m_read, set timeout=1, go to FIN. id_ok and ts_ok are forced to 0.
  - A capture in the same cycle the limit is hit takes priority; it is not a timeout.
- start while busy: ignored, with no queueing.
- start in the same cycle as FIN: ignored.
- start in IDLE while done=1: a new check begins.
- Outputs are registered; there is no combinational path from m_waitrequest to m_read.

Decomposition:
- Shared package `first_nios2_system_pkg`:
  - state enum (IDLE, RD_ID, RD_TS, FIN)
  - offset constants SYSID_OFS_ID=0 and SYSID_OFS_TS=1
  - default EXPECTED_ID/EXPECTED_TS constants
- Sub-module: `first_nios2_system_sysid_checker_wdog`, a saturating wait-cycle counter with clear and expire outputs. The FSM and compare logic stay in the top module.

Test Plan:
- AUTO_START=1, zero-wait slave returning 7 then 1382619795 -> reads at addr 0 then 1 in consecutive cycles; done=1 with id_ok=1, ts_ok=1, timeout=0 on cycle 3 after reset release.
- start pulse, slave stalls 5 cycles on the ID read -> m_read/m_address held steady for 6 cycles; captured_id=7; pass.
- Slave returns ID 8 -> done=1, id_ok=0, ts_ok=1, captured_id=8.
- TIMEOUT_CYCLES=4, waitrequest stuck high -> m_read drops after 4 stall cycles; done=1, timeout=1, id_ok=0, ts_ok=0.
- start re-pulsed during RD_TS, and reset asserted during a stalled read -> the extra start is ignored (one check only); after reset, all outputs read 0 and m_read=0 the next cycle.
- AUTO_START=0 -> stays IDLE with busy=0 until start; then a full pass sequence completes.

Source files
------------

// File: rtl/first_nios2_system_pkg.sv
// Shared definitions for the first_nios2_system sysid checker.
// Covers the FSM state encoding, the sysid register offsets and the default expected values.
package first_nios2_system_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    FIN   = 2'd3
  } sysid_state_t;

  localparam logic SYSID_OFS_ID = 1'b0;
  localparam logic SYSID_OFS_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd7;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1382619795;

endpackage

// File: rtl/first_nios2_system_sysid_checker_wdog.sv
// Saturating wait-cycle counter that bounds how long one Avalon read may stall.
// The expire output is combinational and fires on the stalled cycle that reaches LIMIT.
module first_nios2_system_sysid_checker_wdog #(
  parameter int LIMIT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int               CNT_W = $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // count holds the stalls already seen, so this stall is number LIMIT
  assign expire = inc && (count == LAST);

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words.
// It checks both words against build-time constants and reports pass, fail or timeout.
module first_nios2_system_sysid_checker
  import first_nios2_system_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          AUTO_START     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  sysid_state_t state, next_state;
  logic         auto_pend;
  logic         go;
  logic         rd_active;
  logic         rd_ack;
  logic         expire;

  assign go        = start | auto_pend;
  assign rd_active = (state == RD_ID) || (state == RD_TS);
  assign rd_ack    = rd_active & m_read & ~m_waitrequest;

  first_nios2_system_sysid_checker_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clr    (state != next_state),
    .inc    (rd_active & m_waitrequest),
    .expire (expire)
  );

  // Armed during reset so that the first cycle after release starts a check
  always_ff @(posedge clock) begin
    if (reset) begin
      auto_pend <= (AUTO_START != 0);
    end else begin
      auto_pend <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (go) next_state = RD_ID;
      RD_ID:   if (rd_ack) next_state = RD_TS;
               else if (expire) next_state = FIN;
      RD_TS:   if (rd_ack || expire) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered on the transition into each state
  always_ff @(posedge clock) begin
    if (reset) begin
      m_read      <= 1'b0;
      m_address   <= SYSID_OFS_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            m_read    <= 1'b1;
            m_address <= SYSID_OFS_ID;
            busy      <= 1'b1;
            done      <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        RD_ID: begin
          if (rd_ack) begin
            captured_id <= m_readdata;
            m_address   <= SYSID_OFS_TS;
          end else if (expire) begin
            m_read  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
          end
        end
        RD_TS: begin
          // Timestamp compare uses the bus word directly since it lands this edge
          if (rd_ack) begin
            captured_ts <= m_readdata;
            m_read      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            id_ok       <= (captured_id == EXPECTED_ID);
            ts_ok       <= (m_readdata == EXPECTED_TS);
          end else if (expire) begin
            m_read  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
